// File: rtl/lutram_scan_ctrl.sv
// lutram_scan_ctrl: self-test sequencer for one single-port 1-bit LUTRAM.
// A start pulse runs CHK_INIT, WR_INV and CHK_INV, then FIN. The scan reports
// pass/fail, a saturating mismatch count and the first failing address and phase.
// Optional macro LUTRAM_SCAN_RESTORE_EN appends WR_RST and CHK_RST before FIN.
// These two phases rewrite INIT and verify it, so the scan can be repeated.
module lutram_scan_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter logic [(2**ADDR_W)-1:0] INIT = 64'hFEDCBA9876543210,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic              ram_d_o,
    input  logic              ram_q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [1:0]        first_err_phase_o
);

`ifdef LUTRAM_SCAN_RESTORE_EN
    typedef enum logic [2:0] {
        StIdle, StChkInit, StWrInv, StChkInv, StWrRst, StChkRst, StFin
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StChkInit, StWrInv, StChkInv, StFin
    } state_e;
`endif

    // Phase codes reported on first_err_phase_o
    localparam logic [1:0] PhNone    = 2'd0;
    localparam logic [1:0] PhChkInit = 2'd1;
    localparam logic [1:0] PhChkInv  = 2'd2;
    localparam logic [1:0] PhChkRst  = 2'd3;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic                r_we, w_we_d;
    logic                r_d, w_d_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;
    logic                r_pass, w_pass_d;
    logic [ERR_W-1:0]    r_err_cnt, w_err_d;
    logic [ADDR_W-1:0]   r_first_addr, w_first_addr_d;
    logic [1:0]          r_first_phase, w_first_phase_d;

    // Per-cycle helpers
    logic                w_last;
    logic                w_exp;
    logic [1:0]          w_code;

    // Next-state, compare/count and registered-output preparation
    always_comb begin
        w_state_d       = r_state;
        w_addr_d        = '0;
        w_we_d          = 1'b0;
        w_d_d           = 1'b0;
        w_busy_d        = r_busy;
        w_done_d        = 1'b0;
        w_pass_d        = r_pass;
        w_err_d         = r_err_cnt;
        w_first_addr_d  = r_first_addr;
        w_first_phase_d = r_first_phase;
        w_last          = &r_addr;
        w_exp           = INIT[r_addr];
        w_code          = PhNone;

        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_d       = StChkInit;
                    w_busy_d        = 1'b1;
                    w_pass_d        = 1'b0;
                    w_err_d         = '0;
                    w_first_addr_d  = '0;
                    w_first_phase_d = PhNone;
                end
            end
            StChkInit: begin
                w_code   = PhChkInit;
                w_addr_d = r_addr + 1'b1;
                if (w_last) begin
                    w_state_d = StWrInv;
                end
            end
            StWrInv: begin
                w_addr_d = r_addr + 1'b1;
                if (w_last) begin
                    w_state_d = StChkInv;
                end
            end
            StChkInv: begin
                w_code   = PhChkInv;
                w_exp    = ~INIT[r_addr];
                w_addr_d = r_addr + 1'b1;
                if (w_last) begin
`ifdef LUTRAM_SCAN_RESTORE_EN
                    w_state_d = StWrRst;
`else
                    w_state_d = StFin;
`endif
                end
            end
`ifdef LUTRAM_SCAN_RESTORE_EN
            StWrRst: begin
                w_addr_d = r_addr + 1'b1;
                if (w_last) begin
                    w_state_d = StChkRst;
                end
            end
            StChkRst: begin
                w_code   = PhChkRst;
                w_addr_d = r_addr + 1'b1;
                if (w_last) begin
                    w_state_d = StFin;
                end
            end
`endif
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Compare only in check phases; count saturates, first failure is sticky
        if ((w_code != PhNone) && (ram_q_i != w_exp)) begin
            if (r_err_cnt != '1) begin
                w_err_d = r_err_cnt + 1'b1;
            end
            if (r_err_cnt == '0) begin
                w_first_addr_d  = r_addr;
                w_first_phase_d = w_code;
            end
        end

        // Verdict uses the count including the final compare of the last phase
        if ((w_state_d == StFin) && (r_state != StFin)) begin
            w_busy_d = 1'b0;
            w_done_d = 1'b1;
            w_pass_d = (w_err_d == '0);
        end

        // Write strobe and data line up with the address presented next cycle
        case (w_state_d)
            StWrInv: begin
                w_we_d = 1'b1;
                w_d_d  = ~INIT[w_addr_d];
            end
`ifdef LUTRAM_SCAN_RESTORE_EN
            StWrRst: begin
                w_we_d = 1'b1;
                w_d_d  = INIT[w_addr_d];
            end
`endif
            default: begin
                w_we_d = 1'b0;
                w_d_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_d           <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_cnt     <= '0;
            r_first_addr  <= '0;
            r_first_phase <= PhNone;
        end else begin
            r_state       <= w_state_d;
            r_addr        <= w_addr_d;
            r_we          <= w_we_d;
            r_d           <= w_d_d;
            r_busy        <= w_busy_d;
            r_done        <= w_done_d;
            r_pass        <= w_pass_d;
            r_err_cnt     <= w_err_d;
            r_first_addr  <= w_first_addr_d;
            r_first_phase <= w_first_phase_d;
        end
    end

    assign ram_addr_o        = r_addr;
    assign ram_we_o          = r_we;
    assign ram_d_o           = r_d;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign pass_o            = r_pass;
    assign err_cnt_o         = r_err_cnt;
    assign first_err_addr_o  = r_first_addr;
    assign first_err_phase_o = r_first_phase;

endmodule

// File: tb/tb_lutram_scan_ctrl.sv
// Bench for lutram_scan_ctrl: two instances, one with the default ERR_W and one with ERR_W=2.
// Each instance drives a behavioural 64x1 async-read RAM. Expected results come from a
// phase-by-phase reference walk over an array image of the RAM.
module tb_lutram_scan_ctrl;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam logic [63:0] INIT   = 64'hFEDCBA9876543210;
`ifdef LUTRAM_SCAN_RESTORE_EN
    localparam int LAT = 5 * DEPTH + 1;
`else
    localparam int LAT = 3 * DEPTH + 1;
`endif

    logic clk = 1'b0;
    logic rst, start_a, start_s;

    logic [ADDR_W-1:0] a_addr, a_faddr, s_addr, s_faddr;
    logic a_we, a_d, a_q, a_busy, a_done, a_pass;
    logic s_we, s_d, s_q, s_busy, s_done, s_pass;
    logic [7:0] a_err;
    logic [1:0] s_err, a_fphase, s_fphase;

    logic [63:0] mem_a, mem_s, load_val;
    logic load_a, load_s;
    logic stuck_en, stuck_val;
    logic [ADDR_W-1:0] stuck_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lutram_scan_ctrl #(.ADDR_W(ADDR_W), .INIT(INIT), .ERR_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .ram_addr_o(a_addr), .ram_we_o(a_we), .ram_d_o(a_d), .ram_q_i(a_q),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err),
        .first_err_addr_o(a_faddr), .first_err_phase_o(a_fphase)
    );

    lutram_scan_ctrl #(.ADDR_W(ADDR_W), .INIT(INIT), .ERR_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start_s),
        .ram_addr_o(s_addr), .ram_we_o(s_we), .ram_d_o(s_d), .ram_q_i(s_q),
        .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err),
        .first_err_addr_o(s_faddr), .first_err_phase_o(s_fphase)
    );

    // RAM models: write at clock edge, asynchronous read
    always @(posedge clk) begin
        if (load_a) mem_a <= load_val;
        else if (a_we) mem_a[a_addr] <= a_d;
    end
    always @(posedge clk) begin
        if (load_s) mem_s <= load_val;
        else if (s_we) mem_s[s_addr] <= s_d;
    end
    assign a_q = (stuck_en && (a_addr == stuck_addr)) ? stuck_val : mem_a[a_addr];
    assign s_q = ~mem_s[s_addr];

    // Reference: walk the phase list over an array image of the RAM
    task automatic ref_scan(input logic [63:0] m_in, input bit st_en, input int st_addr,
                            input bit st_val, input bit inv, input int max_err,
                            output int err, output int faddr, output int fphase,
                            output logic [63:0] m_out);
        logic [63:0] m, init_v;
        int kinds[$];
        logic q, e;
        m = m_in;
        init_v = INIT;
        err = 0;
        faddr = 0;
        fphase = 0;
        // positive: check with phase code; -1: write ~INIT; -2: write INIT
        kinds = {1, -1, 2};
`ifdef LUTRAM_SCAN_RESTORE_EN
        kinds.push_back(-2);
        kinds.push_back(3);
`endif
        foreach (kinds[k]) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (kinds[k] > 0) begin
                    q = (st_en && a == st_addr) ? st_val : m[a];
                    q = q ^ inv;
                    e = (kinds[k] == 2) ? ~init_v[a] : init_v[a];
                    if (q !== e) begin
                        if (err == 0) begin
                            faddr = a;
                            fphase = kinds[k];
                        end
                        if (err < max_err) err++;
                    end
                end else if (kinds[k] == -1) begin
                    m[a] = ~init_v[a];
                end else begin
                    m[a] = init_v[a];
                end
            end
        end
        m_out = m;
    endtask

    task automatic load(input bit sel, input logic [63:0] v);
        @(negedge clk);
        load_val = v;
        if (sel) load_s = 1'b1;
        else load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        load_s = 1'b0;
    endtask

    // Pulse start, optionally re-pulse at cycles x1/x2; cycle 1 follows the start edge
    task automatic scan(input bit sel, input int x1, input int x2,
                        output int lat_done, output int busy_cyc, output int dones);
        int lat;
        lat_done = 0;
        busy_cyc = 0;
        dones = 0;
        @(negedge clk);
        if (sel) start_s = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_s = 1'b0;
        lat = 1;
        while (lat < LAT + 40) begin
            if (sel ? s_done : a_done) begin
                dones++;
                if (lat_done == 0) lat_done = lat;
            end
            if (sel ? s_busy : a_busy) busy_cyc++;
            if (lat_done != 0 && lat >= lat_done + 3) break;
            if (lat == x1 || lat == x2) begin
                if (sel) start_s = 1'b1;
                else start_a = 1'b1;
            end
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_s = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1;
        start_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_we, a_d} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {a_busy, a_done, a_pass, a_we, a_d});
        end
        checks++;
        if ({a_err, a_addr, a_faddr, a_fphase} !== '0) begin
            errors++;
            $display("FAIL reset_values: err=%0d addr=%0d faddr=%0d fphase=%0d want all 0",
                     a_err, a_addr, a_faddr, a_fphase);
        end
        checks++;
        if ({s_busy, s_done, s_pass, s_err, s_fphase} !== '0) begin
            errors++;
            $display("FAIL reset_sat: busy=%b err=%0d want 0", s_busy, s_err);
        end
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        start_s = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b want 0", a_busy);
        end
    endtask

    task automatic test_clean_scan();
        logic [63:0] r;
        int e_err, e_fa, e_fp, lat, bc, nd;
        load(1'b0, INIT);
        ref_scan(INIT, 0, 0, 0, 0, 255, e_err, e_fa, e_fp, r);
        scan(1'b0, -1, -1, lat, bc, nd);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL clean_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bc !== LAT - 1 || nd !== 1) begin
            errors++;
            $display("FAIL clean_busy_done: busy=%0d dones=%0d want %0d 1", bc, nd, LAT - 1);
        end
        checks++;
        if (a_pass !== 1'b1 || a_err !== e_err[7:0]) begin
            errors++;
            $display("FAIL clean_result: pass=%b err=%0d want 1 %0d", a_pass, a_err, e_err);
        end
        checks++;
        if (mem_a !== r) begin
            errors++;
            $display("FAIL clean_ram: got %h want %h", mem_a, r);
        end
    endtask

    task automatic test_stuck_at();
        logic [63:0] r;
        int e_err, e_fa, e_fp, lat, bc, nd, sa;
        bit sv;
        for (int it = 0; it < 3; it++) begin
            sa = (it == 0) ? 5 : int'($urandom_range(0, DEPTH - 1));
            sv = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            load(1'b0, INIT);
            stuck_addr = sa[ADDR_W-1:0];
            stuck_val = sv;
            stuck_en = 1'b1;
            ref_scan(INIT, 1, sa, sv, 0, 255, e_err, e_fa, e_fp, r);
            scan(1'b0, -1, -1, lat, bc, nd);
            checks++;
            if (a_err !== e_err[7:0] || a_pass !== (e_err == 0)) begin
                errors++;
                $display("FAIL stuck_count[%0d]: err=%0d pass=%b want %0d %b",
                         sa, a_err, a_pass, e_err, e_err == 0);
            end
            checks++;
            if (a_faddr !== e_fa[ADDR_W-1:0] || a_fphase !== e_fp[1:0]) begin
                errors++;
                $display("FAIL stuck_first[%0d]: addr=%0d phase=%0d want %0d %0d",
                         sa, a_faddr, a_fphase, e_fa, e_fp);
            end
            checks++;
            if (lat !== LAT || mem_a !== r) begin
                errors++;
                $display("FAIL stuck_lat_ram[%0d]: lat=%0d ram=%h want %0d %h",
                         sa, lat, mem_a, LAT, r);
            end
            stuck_en = 1'b0;
        end
    endtask

    task automatic test_saturation();
        logic [63:0] r;
        int e_err, e_fa, e_fp, lat, bc, nd;
        load(1'b1, INIT);
        ref_scan(INIT, 0, 0, 0, 1, 3, e_err, e_fa, e_fp, r);
        scan(1'b1, -1, -1, lat, bc, nd);
        checks++;
        if (s_err !== e_err[1:0] || s_pass !== 1'b0) begin
            errors++;
            $display("FAIL sat_count: err=%0d pass=%b want %0d 0", s_err, s_pass, e_err);
        end
        checks++;
        if (s_faddr !== e_fa[ADDR_W-1:0] || s_fphase !== e_fp[1:0]) begin
            errors++;
            $display("FAIL sat_first: addr=%0d phase=%0d want %0d %0d",
                     s_faddr, s_fphase, e_fa, e_fp);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL sat_latency: got %0d want %0d", lat, LAT);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [63:0] part, r, init_v;
        int e_err, e_fa, e_fp, lat, bc, nd, rc;
        init_v = INIT;
        rc = int'($urandom_range(DEPTH + 1, 2 * DEPTH));
        load(1'b0, INIT);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (rc - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_we, a_d, a_err, a_addr, a_faddr, a_fphase} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs[%0d]: busy=%b we=%b addr=%0d err=%0d want all 0",
                     rc, a_busy, a_we, a_addr, a_err);
        end
        // Edges DEPTH+1 .. rc wrote addresses 0 .. rc-DEPTH-1 with ~INIT
        part = init_v;
        for (int a = 0; a <= rc - DEPTH - 1; a++) part[a] = ~init_v[a];
        checks++;
        if (mem_a !== part) begin
            errors++;
            $display("FAIL midreset_ram[%0d]: got %h want %h", rc, mem_a, part);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stays_idle: busy=%b want 0", a_busy);
        end
        ref_scan(part, 0, 0, 0, 0, 255, e_err, e_fa, e_fp, r);
        scan(1'b0, -1, -1, lat, bc, nd);
        checks++;
        if (a_err !== e_err[7:0] || a_faddr !== e_fa[ADDR_W-1:0] || a_fphase !== e_fp[1:0]) begin
            errors++;
            $display("FAIL midreset_rescan: err=%0d addr=%0d phase=%0d want %0d %0d %0d",
                     a_err, a_faddr, a_fphase, e_err, e_fa, e_fp);
        end
        checks++;
        if (lat !== LAT || a_pass !== (e_err == 0)) begin
            errors++;
            $display("FAIL midreset_lat_pass: lat=%0d pass=%b want %0d %b",
                     lat, a_pass, LAT, e_err == 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int e_err, e_fa, e_fp, lat, bc, nd;
        load(1'b0, INIT);
        r = INIT;
        for (int n = 0; n < 2; n++) begin
            ref_scan(r, 0, 0, 0, 0, 255, e_err, e_fa, e_fp, r);
            scan(1'b0, 10, LAT, lat, bc, nd);
            checks++;
            if (lat !== LAT || nd !== 1 || bc !== LAT - 1) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: lat=%0d dones=%0d busy=%0d want %0d 1 %0d",
                         n, lat, nd, bc, LAT, LAT - 1);
            end
            checks++;
            if (a_pass !== (e_err == 0) || a_err !== e_err[7:0] || a_fphase !== e_fp[1:0]) begin
                errors++;
                $display("FAIL b2b_result[%0d]: pass=%b err=%0d phase=%0d want %b %0d %0d",
                         n, a_pass, a_err, a_fphase, e_err == 0, e_err, e_fp);
            end
            checks++;
            if (mem_a !== r) begin
                errors++;
                $display("FAIL b2b_ram[%0d]: got %h want %h", n, mem_a, r);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_s = 1'b0;
        load_a = 1'b0;
        load_s = 1'b0;
        load_val = '0;
        stuck_en = 1'b0;
        stuck_val = 1'b0;
        stuck_addr = '0;
        test_reset();
        test_clean_scan();
        test_stuck_at();
        test_saturation();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/lutram_scan_ctrl.md
Name: lutram_scan_ctrl

Overview:
- Self-test sequencer for one single-port, 1-bit-wide LUTRAM primitive (RAM64X1S-class) instantiated beside it in a test top.
- On a start pulse it runs three phases:
  - reads every address and checks it against the INIT pattern;
  - writes the inverse pattern;
  - reads it back and checks it.
- Reports pass/fail, a saturating error count and the first failing address/phase, for display on board LEDs.

Parameters:
- ADDR_W, 6, LUTRAM address width; DEPTH = 2**ADDR_W.
- INIT, 64'hFEDCBA9876543210, [DEPTH-1:0] expected power-up contents; bit n = word at address n. Must match the INIT given to the LUTRAM instance.
- ERR_W, 8, width of error counter.

Ports:
- clk_i  in  1  clock, from BUFG; also drives LUTRAM write clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start request.
- ram_addr_o  out  ADDR_W  LUTRAM address (A[ADDR_W-1:0]).
- ram_we_o  out  1  LUTRAM write enable.
- ram_d_o  out  1  LUTRAM write data.
- ram_q_i  in  1  LUTRAM asynchronous read data for ram_addr_o.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan completion.
- pass_o  out  1  last completed scan had zero mismatches.
- err_cnt_o  out  ERR_W  mismatch count of last/current scan, saturating.
- first_err_addr_o  out  ADDR_W  address of first mismatch.
- first_err_phase_o  out  2  phase of first mismatch: 1 = CHK_INIT, 2 = CHK_INV, 3 = CHK_RST.

Behaviour:
- Reset (rst_i high at a clk_i edge) forces all outputs to 0 and state to IDLE, including mid-scan. LUTRAM contents are not repaired. A scan is only restarted by a new start_i.
- States: IDLE, CHK_INIT, WR_INV, CHK_INV, [WR_RST, CHK_RST], FIN.
- Address counter:
  - All outputs are registered.
  - ram_addr_o = 0 on entering each non-IDLE phase and increments by 1 each cycle.
  - On reaching DEPTH-1, the next cycle enters the next phase with address 0. No idle cycles between phases.
- IDLE:
  - start_i=1 → CHK_INIT next cycle.
  - Same edge: busy_o←1, err_cnt_o←0, first_err_addr_o←0, first_err_phase_o←0, pass_o←0.
  - start_i while busy_o=1 is ignored.
- CHK phases:
  - ram_we_o=0.
  - Each cycle compare ram_q_i against the expected bit for the current ram_addr_o: INIT[addr] in CHK_INIT/CHK_RST, ~INIT[addr] in CHK_INV.
  - Mismatch: err_cnt_o increments at that edge, saturating at 2**ERR_W-1.
  - If err_cnt_o was 0, first_err_addr_o/first_err_phase_o capture the address/phase at that edge.
- WR phases:
  - ram_we_o=1, ram_d_o = ~INIT[addr] (WR_INV) or INIT[addr] (WR_RST). No compare.
  - Write takes effect at the same clk_i edge that advances the address.
- Exiting the last CHK phase goes to FIN for one cycle: done_o=1, busy_o=0, pass_o=(err_cnt_o==0). Then → IDLE.
- Outside active phases: ram_we_o=0, ram_d_o=0, ram_addr_o=0.
- pass_o/err_cnt_o/first_err_* hold until next accepted start or reset.
- Latency: start edge → done_o high = 3*DEPTH+1 cycles (5*DEPTH+1 with restore).
- start_i coincident with the FIN cycle is ignored. Only IDLE accepts start_i.
- Simultaneous rst_i and start_i: reset wins.

Optional Feature:
- Macro: LUTRAM_SCAN_RESTORE_EN.
- Defined: after CHK_INV the sequence runs WR_RST (rewrite INIT) then CHK_RST (verify) before FIN. The LUTRAM ends with its original contents, so the scan is repeatable.
- Undefined: CHK_INV → FIN. WR_RST/CHK_RST are absent, and phase code 3 is never produced. The LUTRAM is left holding ~INIT, so a second scan fails in CHK_INIT.

Test Plan (bench uses a behavioural 64x1 async-read RAM model preloaded with INIT; defaults):
- Clean scan: pulse start_i → busy_o high for 192 cycles, done_o pulse at cycle 193, pass_o=1, err_cnt_o=0. Model ends holding ~INIT (64'h0123456789ABCDEF) without macro, INIT with macro.
- Stuck-at: model address 5 stuck at 1 (INIT[5]=0) → CHK_INIT mismatch at 5. CHK_INV reads 1 where ~INIT[5]=1, so it passes. Result: err_cnt_o=1, first_err_addr_o=5, first_err_phase_o=1, pass_o=0.
- Saturation: ERR_W=2, model read output inverted → err_cnt_o stops at 3, first_err_addr_o=0, first_err_phase_o=1.
- Reset mid-scan: rst_i at cycle 70 (in WR_INV) → next cycle all outputs 0, state IDLE. A later start_i runs a full scan that reports errors for addresses 0..5 in CHK_INIT (already inverted).
- Start while busy: extra start_i pulses at cycles 10 and 193 → ignored, exactly one done_o pulse, total 193 cycles.
- Restore (macro defined): two back-to-back scans → both pass_o=1, each done_o 321 cycles after its start.
